tdc_pair_acc: RTL
=================

# tdc_pair_acc

Parametrised pair combiner for the TDC measurement path. Groups consecutive samples from the multiplier stream into (A, B) pairs and forms A+B or B−A per pair. Accumulates 2^ACC_LOG2 pairs, then scales, clips and publishes the result with a stretched valid for the downstream FIFO/UART writer. Adds phase resynchronisation, a runtime mode, accumulation depth and overflow reporting.

## Interface
- IN_W, 37: input sample width, unsigned.
- OUT_W, 20: output width, two's complement.
- ACC_LOG2, 0: log2 of the number of pairs summed per output (0 → every pair).
- OUT_LSB, 0: arithmetic right shift applied to the accumulated result before clipping.
- DVAL_LEN, 16: o_dval high-time in clk cycles; ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_dval  in  1  input sample strobe, one sample per high cycle.
- i_data  in  IN_W  sample value.
- i_mode  in  1  0 = A+B, 1 = B−A; sampled on the cycle B is accepted.
- i_sync  in  1  phase marker (replaces the 10/20 kHz flag); forces pair realignment.
- o_data  out  OUT_W  result, held until the next result.
- o_dval  out  1  high for DVAL_LEN cycles after each o_data update.
- o_sat  out  1  result was clipped; updates with o_data.
- o_drop  out  1  one-cycle pulse: a held A sample was discarded.

## Operation
- Pair FSM, two states:
  - S_A: i_dval → A ← i_data, go to S_B.
  - S_B: i_dval → B ← i_data, latch i_mode, pair_v pulse, go to S_A.
- i_sync & i_dval in any state: the sample is taken as A and the state becomes S_B. If the state was S_B, o_drop pulses.
- i_sync without i_dval: the state becomes S_A. If the state was S_B, o_drop pulses.
- Combine stage: comb = A+B or B−A, computed signed at IN_W+2 bits, with no loss.
- Accumulator: IN_W+2+ACC_LOG2 bits, signed, pair counter of ACC_LOG2 bits.
  - On the last pair of a group, res = acc + comb, then acc ← 0 and the counter ← 0.
  - Otherwise acc ← acc + comb.
- Output: o_data ← clip(res >>> OUT_LSB) to the OUT_W signed range, and o_sat ← 1 if clipped, else 0.
- o_dval counter: loads DVAL_LEN on every o_data update. A retrigger while it is running reloads it, so o_dval stays high.
- Reset at any point clears:
  - the FSM to S_A;
  - A, B, comb, acc and the counters;
  - o_data = 0, o_dval = 0, o_sat = 0, o_drop = 0.

  Partial pairs and partial groups are lost.

## Timing
- B accepted in cycle n (i_dval high):
  - comb is valid at n+1;
  - res is valid at n+2;
  - o_data, o_sat and the start of o_dval are visible at n+3.
- o_dval is high for cycles n+3 … n+3+DVAL_LEN−1.
- Full throughput: i_dval may be high every cycle, giving one pair per 2 cycles. No backpressure; the pipeline never stalls.
- o_drop is asserted in the cycle after the offending i_sync edge.
- Simultaneous result output and new input acceptance are independent; no interaction.

## Configuration
- PAIR_SAT_EN defined: saturating clip as described; o_sat is functional.
- PAIR_SAT_EN undefined: o_data = low OUT_W bits of (res >>> OUT_LSB) (wrap-around); o_sat is tied 0.

## Structure
- Shared package tdc_pkg holds:
  - the pair-state enum (S_A, S_B);
  - the mode encoding constants (MODE_SUM = 0, MODE_DIFF = 1);
  - the DVAL_LEN default.
- One sub-module, tdc_sat_clip: parametrised in/out width; combinational shift + clip/wrap + sat flag. Contains the PAIR_SAT_EN switch.
- The FSM, pipeline and dval stretcher stay in tdc_pair_acc.

## Test plan
1. Sum: A=100, B=250, i_mode=0 → o_data=350 at n+3; o_dval high exactly 16 cycles; o_sat=0.
2. Difference: A=300, B=100, i_mode=1 → o_data=20'hFFF38 (−200).
3. Overflow: A=B=2^20, i_mode=0.
   - With PAIR_SAT_EN → o_data=20'h7FFFF, o_sat=1.
   - Without → o_data=20'h00000, o_sat=0.
4. Resync: dval 5; then sync+dval 7; then dval 9 → o_drop one-cycle pulse; o_data=16.
5. ACC_LOG2=2: four pairs each summing to 10 → exactly one output, o_data=40, 3 cycles after the 4th B; no o_dval earlier.
6. Reset after A=5 is accepted, then pair 1/2 → o_data=0 during reset, then o_data=3; no stale A.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC pair combiner path.
package tdc_pkg;

  typedef enum logic {
    S_A = 1'b0,
    S_B = 1'b1
  } pair_state_t;

  localparam logic MODE_SUM  = 1'b0;
  localparam logic MODE_DIFF = 1'b1;

  localparam int DVAL_LEN_DEF = 16;

endpackage

// File: rtl/tdc_sat_clip.sv
// Arithmetic right shift, then narrow to OUT_W with saturation (PAIR_SAT_EN)
// or plain wrap-around (default build, sat tied low).
module tdc_sat_clip #(
  parameter int IN_W  = 39,
  parameter int OUT_W = 20,
  parameter int SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    sat
);

  logic signed [IN_W-1:0] shifted;
  assign shifted = din >>> SHIFT;

`ifdef PAIR_SAT_EN
  generate
    if (OUT_W >= IN_W) begin : g_wide
      assign dout = OUT_W'(shifted);
      assign sat  = 1'b0;
    end else begin : g_clip
      // Value fits only when every bit from the sign down to OUT_W-1 agrees.
      logic [IN_W-OUT_W:0] top;
      logic                ovf;
      assign top = shifted[IN_W-1:OUT_W-1];
      assign ovf = ~((&top) | ~(|top));

      // NOTE: outputs get defaults before the if so no latch is inferred.
      always_comb begin
        dout = shifted[OUT_W-1:0];
        sat  = 1'b0;
        if (ovf) begin
          sat  = 1'b1;
          dout = shifted[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end
  endgenerate
`else
  generate
    if (OUT_W >= IN_W) begin : g_wide
      assign dout = OUT_W'(shifted);
    end else begin : g_wrap
      logic unused_high;
      assign unused_high = ^shifted[IN_W-1:OUT_W];
      assign dout        = shifted[OUT_W-1:0];
    end
  endgenerate
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/tdc_pair_acc.sv
// Pairs consecutive samples into A+B / B-A, accumulates 2^ACC_LOG2 pairs and
// publishes a scaled, clipped result with stretched valid. PAIR_SAT_EN selects saturation.
module tdc_pair_acc
  import tdc_pkg::*;
#(
  parameter int IN_W     = 37,
  parameter int OUT_W    = 20,
  parameter int ACC_LOG2 = 0,
  parameter int OUT_LSB  = 0,
  parameter int DVAL_LEN = DVAL_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_dval,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_mode,
  input  logic             i_sync,
  output logic [OUT_W-1:0] o_data,
  output logic             o_dval,
  output logic             o_sat,
  output logic             o_drop
);

  localparam int CMB_W  = IN_W + 2;
  localparam int ACC_W  = CMB_W + ACC_LOG2;
  localparam int CNT_W  = ACC_LOG2 + 1;
  localparam int DCNT_W = (DVAL_LEN > 1) ? $clog2(DVAL_LEN) : 1;

  localparam logic [CNT_W-1:0]  GRP_LAST  = CNT_W'((1 << ACC_LOG2) - 1);
  localparam logic [DCNT_W-1:0] DVAL_LOAD = DCNT_W'(DVAL_LEN - 1);

  pair_state_t              state;
  logic [IN_W-1:0]          a_q;
  logic signed [CMB_W-1:0]  a_ext, b_ext, comb_next, comb_q;
  logic                     comb_v;

  logic signed [ACC_W-1:0]  acc_q, sum_next, res_q;
  logic [CNT_W-1:0]         grp_cnt;
  logic                     grp_last, res_v;

  logic [OUT_W-1:0]         clip_data;
  logic                     clip_sat;
  logic [DCNT_W-1:0]        dcnt;

  // Both operands are unsigned, so two zero guard bits keep A+B and B-A exact.
  assign a_ext     = signed'({2'b00, a_q});
  assign b_ext     = signed'({2'b00, i_data});
  assign comb_next = (i_mode == MODE_DIFF) ? (b_ext - a_ext) : (a_ext + b_ext);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: A is cleared too, so a half pair never survives a reset.
      state  <= S_A;
      a_q    <= '0;
      comb_q <= '0;
      comb_v <= 1'b0;
      o_drop <= 1'b0;
    end else begin
      comb_v <= 1'b0;
      o_drop <= 1'b0;
      if (i_sync) begin
        o_drop <= (state == S_B);
        if (i_dval) begin
          a_q   <= i_data;
          state <= S_B;
        end else begin
          state <= S_A;
        end
      end else if (i_dval) begin
        unique case (state)
          S_A: begin
            a_q   <= i_data;
            state <= S_B;
          end
          S_B: begin
            comb_q <= comb_next;
            comb_v <= 1'b1;
            state  <= S_A;
          end
        endcase
      end
    end
  end

  assign sum_next = acc_q + ACC_W'(comb_q);
  assign grp_last = (grp_cnt == GRP_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      grp_cnt <= '0;
      res_q   <= '0;
      res_v   <= 1'b0;
    end else begin
      res_v <= 1'b0;
      if (comb_v) begin
        if (grp_last) begin
          res_q   <= sum_next;
          res_v   <= 1'b1;
          acc_q   <= '0;
          grp_cnt <= '0;
        end else begin
          acc_q   <= sum_next;
          grp_cnt <= grp_cnt + 1'b1;
        end
      end
    end
  end

  tdc_sat_clip #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (OUT_LSB)
  ) u_clip (
    .din  (res_q),
    .dout (clip_data),
    .sat  (clip_sat)
  );

  // A new result reloads the stretcher, so back-to-back results keep o_dval high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_data <= '0;
      o_sat  <= 1'b0;
      o_dval <= 1'b0;
      dcnt   <= '0;
    end else if (res_v) begin
      o_data <= clip_data;
      o_sat  <= clip_sat;
      o_dval <= 1'b1;
      dcnt   <= DVAL_LOAD;
    end else if (dcnt != '0) begin
      dcnt <= dcnt - 1'b1;
    end else begin
      o_dval <= 1'b0;
    end
  end

endmodule
